mips_alu_mdu: RTL
=================

// Module: mips_alu_mdu
// PURPOSE
// - Parametrised successor to the single-cycle MIPSALU: adds the MIPS multiply/divide unit.
// - Registered ALU ops plus iterative MULTU/DIVU writing internal HI/LO; MFHI/MFLO read them back.
// - Start/busy/done handshake. Sits in the EX stage of the multi-cycle datapath.
// - Controller stalls on busy.
// PARAMETERS
// - WIDTH  32  operand/result width (>=4); HI, LO and ALUOut are WIDTH bits
// PORTS
// - clock   in   1      single clock; all state updates on posedge
// - reset   in   1      synchronous, active-high
// - start   in   1      request; accepted only in IDLE
// - ALUctl  in   4      operation, sampled with accepted start
// - A, B    in   WIDTH  operands, sampled with accepted start
// - ALUOut  out  WIDTH  registered result; held until next done
// - Zero    out  1      registered (ALUOut==0)
// - Ovf     out  1      signed overflow of ADD/SUB; 0 for all other ops
// - Err     out  1      unsupported ALUctl; valid with done
// - busy    out  1      high whenever state != IDLE
// - done    out  1      one-cycle pulse; ALUOut/Zero/Ovf/Err valid from this cycle
// BEHAVIOUR
// - Reset: state=IDLE, ALUOut=0, Zero=1, Ovf=0, Err=0, busy=0, done=0, HI=LO=0, count=0.
// - FSM IDLE->DONE (single-cycle op) | IDLE->RUN (MULTU/DIVU); RUN->DONE when count hits 0.
// - FSM DONE->IDLE always. DONE asserts done.
// - start outside IDLE is ignored; no queuing; operands need not be held after acceptance.
// - ALUctl codes:
//   - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
//   - 0111 SLT: signed A<B -> 1, else 0. 1100 NOR.
//   - 1010 MFHI: ALUOut=HI. 1011 MFLO: ALUOut=LO.
//   - 1000 MULTU: unsigned shift-add, one bit/cycle. {HI,LO}=A*B (2*WIDTH bits); ALUOut=LO.
//   - 1001 DIVU: restoring, one bit/cycle. LO=A/B, HI=A%B; ALUOut=LO.
//   - B==0 on DIVU: LO=all ones, HI=A. No trap.
//   - Any other code: ALUOut=0, Zero=1, Err=1, HI/LO unchanged, single-cycle path.
// - Latency, start accepted at edge of cycle 0:
//   - Single-cycle ops: DONE in cycle 1, back in IDLE cycle 2; next start accepted cycle 2.
//   - MULTU/DIVU: RUN for cycles 1..WIDTH (count WIDTH-1 down to 0); DONE in cycle WIDTH+1.
//   - HI/LO written on the edge entering DONE.
// - Arithmetic: ADD/SUB wrap modulo 2^WIDTH.
//   - Ovf = operand signs equal (ADD) / differ (SUB) and result sign differs from A.
// - Zero always matches ALUOut, including on Err.
// - ALUOut/Zero/Ovf/Err change only on the edge entering DONE; stable in IDLE and RUN.
// - Reset mid-RUN: next cycle IDLE, busy=0, partial product/quotient discarded, HI=LO=0.
// - Reset has priority over start in the same cycle.
// CONFIGURATION
// - MIPS_ALU_DIV_EN defined: DIVU (1001) implemented as above.
// - MIPS_ALU_DIV_EN undefined: 1001 is unsupported.
//   - Err=1, ALUOut=0, single-cycle latency, HI/LO unchanged.
//   - Divider datapath not synthesised. MULTU unaffected.
// TESTING (WIDTH=32)
// - ADD A=B=0x55555555 -> cycle 1: done=1, ALUOut=0xAAAAAAAA, Ovf=1, Zero=0.
// - SUB A=B=0x55555555 -> ALUOut=0, Zero=1, Ovf=0.
// - SLT A=0xFFFFFFFF, B=1 -> ALUOut=1.
// - AND/OR/NOR A=B=0x55555555 -> 0x55555555 / 0x55555555 / 0xAAAAAAAA.
// - MULTU A=0xFFFFFFFF, B=2 -> busy cycles 1..33, done cycle 33, ALUOut=LO=0xFFFFFFFE.
//   - Then MFHI -> ALUOut=0x00000001.
// - DIVU A=100, B=7 (macro on) -> done cycle 33, ALUOut=14; MFHI -> 2.
//   - DIVU B=0 -> LO=0xFFFFFFFF, HI=A.
//   - Macro off: DIVU -> done cycle 1, Err=1, ALUOut=0.
// - MULTU started, start pulsed with ADD during RUN -> ignored, MULTU result unchanged.
//   - reset at cycle 10 of a new MULTU -> cycle 11 busy=0, done never pulses; MFLO -> 0.
// - ALUctl=1111 -> done cycle 1, Err=1, ALUOut=0, Zero=1; HI/LO preserved (check via MFLO).

Source files
------------

// File: rtl/mips_alu_mdu.sv
// ============================================================================
//  Module   : mips_alu_mdu
//  Purpose  : Registered MIPS ALU with iterative multiply/divide unit.
//             Single-cycle logic/arithmetic ops, MULTU (shift-add) and DIVU
//             (restoring) at one bit per cycle into internal HI/LO, and
//             MFHI/MFLO readback. Uses a start/busy/done handshake.
//  Config   : MIPS_ALU_DIV_EN - when defined, DIVU (1001) is implemented;
//             otherwise 1001 is reported as unsupported (Err=1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Ovf,
  output logic             Err,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1000;
`ifdef MIPS_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1001;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    count;

  // Iteration registers: acc is the upper half (partial product / remainder),
  // work the lower half (multiplier / dividend being shifted into quotient),
  // opnd the fixed operand (multiplicand / divisor).
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] opnd;
`ifdef MIPS_ALU_DIV_EN
  logic             is_div;
  logic             iter_div;
  logic [WIDTH:0]   rem_shift;
  logic             div_ge;
  logic [WIDTH-1:0] rem_sub;
`endif

  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_err;
  logic             iter_op;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_work;

  // Decode the requested operation and form the single-cycle result.
  always_comb begin
    sum_ab  = A + B;
    diff_ab = A - B;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    iter_op = 1'b0;
`ifdef MIPS_ALU_DIV_EN
    iter_div = 1'b0;
`endif
    case (ALUctl)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOR:  alu_res = ~(A | B);
      OP_ADD: begin
        alu_res = sum_ab;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ab[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ab;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ab[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  alu_res[0] = ($signed(A) < $signed(B));
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      OP_MULTU: iter_op = 1'b1;
`ifdef MIPS_ALU_DIV_EN
      OP_DIVU: begin
        iter_op  = 1'b1;
        iter_div = 1'b1;
      end
`endif
      default: alu_err = 1'b1;
    endcase
  end

  // One iteration step of the multiplier (or divider when enabled).
  always_comb begin
    mul_sum   = {1'b0, acc} + (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    step_acc  = mul_sum[WIDTH:1];
    step_work = {mul_sum[0], work[WIDTH-1:1]};
`ifdef MIPS_ALU_DIV_EN
    rem_shift = {acc, work[WIDTH-1]};
    div_ge    = (rem_shift >= {1'b0, opnd});
    // When div_ge holds the true difference is below 2^WIDTH, so a
    // WIDTH-bit modular subtraction is exact.
    rem_sub   = rem_shift[WIDTH-1:0] - opnd;
    if (is_div) begin
      step_acc  = div_ge ? rem_sub : rem_shift[WIDTH-1:0];
      step_work = {work[WIDTH-2:0], div_ge};
    end
`endif
  end

  // Control FSM, iteration datapath, HI/LO and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      ALUOut <= '0;
      Zero   <= 1'b1;
      Ovf    <= 1'b0;
      Err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      acc    <= '0;
      work   <= '0;
      opnd   <= '0;
`ifdef MIPS_ALU_DIV_EN
      is_div <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (iter_op) begin
              state  <= S_RUN;
              acc    <= '0;
              work   <= A;
              opnd   <= B;
              count  <= CNT_INIT;
`ifdef MIPS_ALU_DIV_EN
              is_div <= iter_div;
`endif
            end else begin
              state  <= S_DONE;
              done   <= 1'b1;
              ALUOut <= alu_res;
              Zero   <= (alu_res == '0);
              Ovf    <= alu_ovf;
              Err    <= alu_err;
            end
          end
        end
        S_RUN: begin
          acc   <= step_acc;
          work  <= step_work;
          count <= count - 1'b1;
          if (count == '0) begin
            state  <= S_DONE;
            done   <= 1'b1;
            hi     <= step_acc;
            lo     <= step_work;
            ALUOut <= step_work;
            Zero   <= (step_work == '0);
            Ovf    <= 1'b0;
            Err    <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
